// File: rtl/pid_param_if.sv
// -----------------------------------------------------------------------------
// pid_param_if -- sample/status bundle for the line-following PID controller.
//
// Signals
//   sample_tick  master->slave  one-cycle request to run one control sample
//   sensors      master->slave  N_SENS line sensors, bit i = 0 -> line under i
//   kp_en/ki_en/kd_en           master->slave  term enables
//   pid_out      slave->master  signed controller output (DW bits)
//   out_valid    slave->master  one-cycle pulse when pid_out updates
//   busy, line_lost, saturated, overrun   slave->master  status flags
// -----------------------------------------------------------------------------
interface pid_param_if #(
  parameter int N_SENS = 4,
  parameter int DW     = 16
);
  logic                 sample_tick;
  logic [N_SENS-1:0]    sensors;
  logic                 kp_en;
  logic                 ki_en;
  logic                 kd_en;
  logic signed [DW-1:0] pid_out;
  logic                 out_valid;
  logic                 busy;
  logic                 line_lost;
  logic                 saturated;
  logic                 overrun;

  modport master (
    output sample_tick, sensors, kp_en, ki_en, kd_en,
    input  pid_out, out_valid, busy, line_lost, saturated, overrun
  );

  modport slave (
    input  sample_tick, sensors, kp_en, ki_en, kd_en,
    output pid_out, out_valid, busy, line_lost, saturated, overrun
  );
endinterface

// File: rtl/pid_param.sv
// -----------------------------------------------------------------------------
// pid_param -- multi-cycle PID controller for a line-following sensor bar.
//
// A sample walks IDLE -> CAP -> TERM -> SUM -> OUT -> IDLE, one state per clock:
//   capture edge : sensors latched (IDLE with sample_tick)
//   CAP          : line position / error derived from the latched sensors
//   TERM         : P, I, D terms computed, integrator and e_prev updated
//   SUM          : P+I+D summed at DW+2 bits and clamped to +/-OUT_MAX
//   OUT          : pid_out, saturated, line_lost updated, out_valid pulses
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   pid_param_if.slave (sample request, sensors, enables, output, flags)
// -----------------------------------------------------------------------------
module pid_param #(
  parameter int N_SENS    = 4,
  parameter int DW        = 16,
  parameter int HALF_STEP = 1000,
  parameter int KP_NUM    = 1,
  parameter int KP_SHIFT  = 1,
  parameter int KI_NUM    = 1,
  parameter int KI_SHIFT  = 4,
  parameter int KD_NUM    = 1,
  parameter int KD_SHIFT  = 1,
  parameter int I_LIM     = 16000,
  parameter int OUT_MAX   = 2047
) (
  input  logic       clk,
  input  logic       rst,
  pid_param_if.slave bus
);

  localparam int PW = 2 * DW;   // product width
  localparam int SW = DW + 2;   // sum width
  localparam int SP = (N_SENS - 1) * HALF_STEP;  // setpoint = bar centre

  localparam logic signed [DW:0]   I_LIM_W = (DW+1)'(I_LIM);
  localparam logic signed [SW-1:0] OMAX_W  = SW'(OUT_MAX);
  localparam logic signed [PW-1:0] KP_W    = PW'(KP_NUM);
  localparam logic signed [PW-1:0] KI_W    = PW'(KI_NUM);
  localparam logic signed [PW-1:0] KD_W    = PW'(KD_NUM);

  typedef enum logic [2:0] {S_IDLE, S_CAP, S_TERM, S_SUM, S_OUT} state_t;

  state_t               state_q, state_d;
  logic [N_SENS-1:0]    sens_q;
  logic signed [DW-1:0] err_q, err_d;
  logic                 lost_q, lost_d;
  logic signed [DW-1:0] e_prev_q;
  logic signed [DW-1:0] integ_q, integ_d;
  logic signed [DW-1:0] p_q, p_d, i_q, i_d, d_q, d_d;
  logic signed [DW-1:0] sum_q, sum_d;
  logic                 sat_q, sat_d;
  logic signed [DW-1:0] pid_out_q;
  logic                 out_valid_q, line_lost_q, saturated_q, overrun_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.sample_tick) state_d = S_CAP;
      S_CAP:   state_d = S_TERM;
      S_TERM:  state_d = S_SUM;
      S_SUM:   state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // CAP: line position from the outermost covered sensors, then error.
  // With no covered sensor the last error's sign steers the robot back.
  // ---------------------------------------------------------------------------
  int lo, hi;

  always_comb begin
    lo     = 0;
    hi     = 0;
    lost_d = 1'b1;
    err_d  = '0;
    for (int i = N_SENS - 1; i >= 0; i--) begin
      if (!sens_q[i]) lo = i;
    end
    for (int i = 0; i < N_SENS; i++) begin
      if (!sens_q[i]) begin
        hi     = i;
        lost_d = 1'b0;
      end
    end
    if (!lost_d)                err_d = DW'(SP - (lo + hi) * HALF_STEP);
    else if (e_prev_q[DW-1])    err_d = DW'(-SP);
    else if (e_prev_q != '0)    err_d = DW'(SP);
  end

  // ---------------------------------------------------------------------------
  // TERM: P, I, D terms. Products are 2*DW wide and shifted arithmetically,
  // so results truncate toward minus infinity.
  // ---------------------------------------------------------------------------
  logic signed [DW:0]   integ_sum, diff;
  logic signed [PW-1:0] p_prod, i_prod, d_prod;
  logic                 hold;

  always_comb begin
    integ_sum = (DW+1)'(err_q) + (DW+1)'(integ_q);
    // Anti-windup: freeze the integrator while the last output was clamped
    // and this error would push it further in the same direction.
    hold = saturated_q && (err_q != '0) && (pid_out_q != '0) &&
           (err_q[DW-1] == pid_out_q[DW-1]);

    if (!bus.ki_en)                  integ_d = '0;
    else if (hold)                   integ_d = integ_q;
    else if (integ_sum > I_LIM_W)    integ_d = DW'(I_LIM_W);
    else if (integ_sum < -I_LIM_W)   integ_d = DW'(-I_LIM_W);
    else                             integ_d = DW'(integ_sum);

    diff   = (DW+1)'(err_q) - (DW+1)'(e_prev_q);
    p_prod = KP_W * PW'(err_q);
    i_prod = KI_W * PW'(integ_d);
    d_prod = KD_W * PW'(diff);

    p_d = bus.kp_en ? DW'(p_prod >>> KP_SHIFT) : '0;
    i_d = bus.ki_en ? DW'(i_prod >>> KI_SHIFT) : '0;
    d_d = bus.kd_en ? DW'(d_prod >>> KD_SHIFT) : '0;
  end

  // ---------------------------------------------------------------------------
  // SUM: widen before adding so the clamp sees the true total.
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0] total;

  always_comb begin
    total = SW'(p_q) + SW'(i_q) + SW'(d_q);
    sat_d = 1'b0;
    sum_d = DW'(total);
    if (total > OMAX_W) begin
      sum_d = DW'(OMAX_W);
      sat_d = 1'b1;
    end else if (total < -OMAX_W) begin
      sum_d = DW'(-OMAX_W);
      sat_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      sens_q      <= '1;
      err_q       <= '0;
      lost_q      <= 1'b0;
      e_prev_q    <= '0;
      integ_q     <= '0;
      p_q         <= '0;
      i_q         <= '0;
      d_q         <= '0;
      sum_q       <= '0;
      sat_q       <= 1'b0;
      pid_out_q   <= '0;
      out_valid_q <= 1'b0;
      line_lost_q <= 1'b0;
      saturated_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= 1'b0;

      if (state_q == S_IDLE && bus.sample_tick) sens_q <= bus.sensors;
      // A tick while a sample is in flight is dropped but remembered.
      if (state_q != S_IDLE && bus.sample_tick) overrun_q <= 1'b1;

      unique case (state_q)
        S_CAP: begin
          err_q  <= err_d;
          lost_q <= lost_d;
        end
        S_TERM: begin
          p_q      <= p_d;
          i_q      <= i_d;
          d_q      <= d_d;
          e_prev_q <= err_q;
        end
        S_SUM: begin
          sum_q <= sum_d;
          sat_q <= sat_d;
        end
        S_OUT: begin
          pid_out_q   <= sum_q;
          saturated_q <= sat_q;
          line_lost_q <= lost_q;
          out_valid_q <= 1'b1;
        end
        default: ;
      endcase

      if (!bus.ki_en)              integ_q <= '0;
      else if (state_q == S_TERM)  integ_q <= integ_d;
    end
  end

  assign bus.pid_out   = pid_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.line_lost = line_lost_q;
  assign bus.saturated = saturated_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_pid_param.sv
// -----------------------------------------------------------------------------
// tb_pid_param -- directed bench for pid_param.
// Two instances see identical stimulus: dut uses default gains, dut_kp0 uses
// KP_SHIFT=0 so proportional saturation and anti-windup become observable.
// -----------------------------------------------------------------------------
module tb_pid_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  pid_param_if #(.N_SENS(4), .DW(16)) if0 ();
  pid_param_if #(.N_SENS(4), .DW(16)) if1 ();

  pid_param dut (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  pid_param #(.KP_SHIFT(0)) dut_kp0 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic [3:0] s, input logic t);
    if0.sensors = s;  if1.sensors = s;
    if0.sample_tick = t;  if1.sample_tick = t;
  endtask

  task automatic set_en(input logic p, input logic i, input logic d);
    if0.kp_en = p;  if0.ki_en = i;  if0.kd_en = d;
    if1.kp_en = p;  if1.ki_en = i;  if1.kd_en = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(4'b1111, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait up to 8 edges for out_valid; lat = edge count, 0 on timeout.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (if0.out_valid) lat = k;
    end
  endtask

  task automatic run_sample(input logic [3:0] s, output int lat);
    @(negedge clk);
    drive(s, 1'b1);
    @(posedge clk); #1;
    drive(s, 1'b0);
    wait_valid(lat);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    set_en(1'b0, 1'b0, 1'b0);
    do_reset();
    checks++; if (if0.pid_out !== 16'sd0)  begin failures++; $display("FAIL rst_pid_out got=%0d exp=0", if0.pid_out); end
    checks++; if (if0.out_valid !== 1'b0)  begin failures++; $display("FAIL rst_out_valid got=%b exp=0", if0.out_valid); end
    checks++; if (if0.busy !== 1'b0)       begin failures++; $display("FAIL rst_busy got=%b exp=0", if0.busy); end
    checks++; if (if0.line_lost !== 1'b0)  begin failures++; $display("FAIL rst_line_lost got=%b exp=0", if0.line_lost); end
    checks++; if (if0.saturated !== 1'b0)  begin failures++; $display("FAIL rst_saturated got=%b exp=0", if0.saturated); end
    checks++; if (if0.overrun !== 1'b0)    begin failures++; $display("FAIL rst_overrun got=%b exp=0", if0.overrun); end
  endtask

  // Centred line, latency and single-cycle out_valid pulse.
  task automatic test_center();
    int lat;
    do_reset();
    set_en(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(4'b1001, 1'b1);
    @(posedge clk); #1;
    drive(4'b1001, 1'b0);
    checks++; if (if0.busy !== 1'b1) begin failures++; $display("FAIL center_busy got=%b exp=1", if0.busy); end
    wait_valid(lat);
    checks++; if (lat != 4)               begin failures++; $display("FAIL center_latency got=%0d exp=4", lat); end
    checks++; if (if0.pid_out !== 16'sd0) begin failures++; $display("FAIL center_pid_out got=%0d exp=0", if0.pid_out); end
    checks++; if (if0.busy !== 1'b0)      begin failures++; $display("FAIL center_busy_idle got=%b exp=0", if0.busy); end
    @(posedge clk); #1;
    checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL center_pulse got=%b exp=0", if0.out_valid); end
    checks++; if (if0.overrun !== 1'b0)   begin failures++; $display("FAIL center_overrun got=%b exp=0", if0.overrun); end
  endtask

  // Proportional only: default gain 1/2, and gain 1 on dut_kp0 which clamps.
  task automatic test_kp();
    int lat;
    do_reset();
    set_en(1'b1, 1'b0, 1'b0);
    run_sample(4'b1110, lat);  // error +3000
    checks++; if (lat != 4)                   begin failures++; $display("FAIL kp_latency got=%0d exp=4", lat); end
    checks++; if (if0.pid_out !== 16'sd1500)  begin failures++; $display("FAIL kp_pos got=%0d exp=1500", if0.pid_out); end
    checks++; if (if0.saturated !== 1'b0)     begin failures++; $display("FAIL kp_pos_sat got=%b exp=0", if0.saturated); end
    checks++; if (if1.pid_out !== 16'sd2047)  begin failures++; $display("FAIL kp0_pos got=%0d exp=2047", if1.pid_out); end
    checks++; if (if1.saturated !== 1'b1)     begin failures++; $display("FAIL kp0_pos_sat got=%b exp=1", if1.saturated); end
    run_sample(4'b0111, lat);  // error -3000
    checks++; if (if0.pid_out !== -16'sd1500) begin failures++; $display("FAIL kp_neg got=%0d exp=-1500", if0.pid_out); end
    checks++; if (if1.pid_out !== -16'sd2047) begin failures++; $display("FAIL kp0_neg got=%0d exp=-2047", if1.pid_out); end
    checks++; if (if1.saturated !== 1'b1)     begin failures++; $display("FAIL kp0_neg_sat got=%b exp=1", if1.saturated); end
    run_sample(4'b1100, lat);  // lo=0 hi=1 -> error +2000
    checks++; if (if0.pid_out !== 16'sd1000)  begin failures++; $display("FAIL kp_two got=%0d exp=1000", if0.pid_out); end
    checks++; if (if1.pid_out !== 16'sd2000)  begin failures++; $display("FAIL kp0_two got=%0d exp=2000", if1.pid_out); end
    checks++; if (if1.saturated !== 1'b0)     begin failures++; $display("FAIL kp0_two_sat got=%b exp=0", if1.saturated); end
  endtask

  // Integral only: accumulation, clamp at I_LIM, floor on negative values.
  task automatic test_ki();
    int lat;
    int exp_ki [7] = '{187, 375, 562, 750, 937, 1000, 1000};
    do_reset();
    set_en(1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 7; n++) begin
      run_sample(4'b1110, lat);
      checks++;
      if (if0.pid_out !== 16'(exp_ki[n])) begin
        failures++;
        $display("FAIL ki_step%0d got=%0d exp=%0d", n, if0.pid_out, exp_ki[n]);
      end
    end
    do_reset();
    set_en(1'b0, 1'b1, 1'b0);
    run_sample(4'b0111, lat);  // integ -3000, -3000/16 floors to -188
    checks++; if (if0.pid_out !== -16'sd188) begin failures++; $display("FAIL ki_floor got=%0d exp=-188", if0.pid_out); end
  endtask

  // Derivative only.
  task automatic test_kd();
    int lat;
    do_reset();
    set_en(1'b0, 1'b0, 1'b1);
    run_sample(4'b1001, lat);
    checks++; if (if0.pid_out !== 16'sd0)     begin failures++; $display("FAIL kd_zero got=%0d exp=0", if0.pid_out); end
    run_sample(4'b1110, lat);
    checks++; if (if0.pid_out !== 16'sd1500)  begin failures++; $display("FAIL kd_step got=%0d exp=1500", if0.pid_out); end
    run_sample(4'b1110, lat);
    checks++; if (if0.pid_out !== 16'sd0)     begin failures++; $display("FAIL kd_flat got=%0d exp=0", if0.pid_out); end
    run_sample(4'b0111, lat);  // delta -6000 -> -3000 -> clamped
    checks++; if (if0.pid_out !== -16'sd2047) begin failures++; $display("FAIL kd_swing got=%0d exp=-2047", if0.pid_out); end
    checks++; if (if0.saturated !== 1'b1)     begin failures++; $display("FAIL kd_swing_sat got=%b exp=1", if0.saturated); end
  endtask

  // Integrator freezes on dut_kp0 while it is saturated in the error's direction.
  task automatic test_antiwindup();
    int lat;
    do_reset();
    set_en(1'b1, 1'b1, 1'b0);
    run_sample(4'b1110, lat);
    checks++; if (if0.pid_out !== 16'sd1687)  begin failures++; $display("FAIL aw_s1 got=%0d exp=1687", if0.pid_out); end
    checks++; if (if1.pid_out !== 16'sd2047)  begin failures++; $display("FAIL aw0_s1 got=%0d exp=2047", if1.pid_out); end
    run_sample(4'b1110, lat);
    checks++; if (if0.pid_out !== 16'sd1875)  begin failures++; $display("FAIL aw_s2 got=%0d exp=1875", if0.pid_out); end
    checks++; if (if1.saturated !== 1'b1)     begin failures++; $display("FAIL aw0_s2_sat got=%b exp=1", if1.saturated); end
    set_en(1'b0, 1'b1, 1'b0);
    run_sample(4'b1110, lat);
    checks++; if (if0.pid_out !== 16'sd562)   begin failures++; $display("FAIL aw_s3 got=%0d exp=562", if0.pid_out); end
    checks++; if (if1.pid_out !== 16'sd187)   begin failures++; $display("FAIL aw0_s3 got=%0d exp=187", if1.pid_out); end
    checks++; if (if1.saturated !== 1'b0)     begin failures++; $display("FAIL aw0_s3_sat got=%b exp=0", if1.saturated); end
  endtask

  // Line loss keeps steering with the last error; a tick while busy is dropped.
  task automatic test_line_lost();
    int lat;
    bit seen;
    do_reset();
    set_en(1'b1, 1'b0, 1'b0);
    run_sample(4'b1110, lat);
    checks++; if (if0.line_lost !== 1'b0) begin failures++; $display("FAIL ll_before got=%b exp=0", if0.line_lost); end
    @(negedge clk);
    drive(4'b1111, 1'b1);
    @(posedge clk); #1;
    drive(4'b1111, 1'b0);
    @(negedge clk);
    drive(4'b1111, 1'b1);
    @(posedge clk); #1;
    drive(4'b1111, 1'b0);
    checks++; if (if0.overrun !== 1'b1)       begin failures++; $display("FAIL ll_overrun got=%b exp=1", if0.overrun); end
    wait_valid(lat);
    checks++; if (lat != 3)                   begin failures++; $display("FAIL ll_latency got=%0d exp=3", lat); end
    checks++; if (if0.line_lost !== 1'b1)     begin failures++; $display("FAIL ll_flag got=%b exp=1", if0.line_lost); end
    checks++; if (if0.pid_out !== 16'sd1500)  begin failures++; $display("FAIL ll_pid_out got=%0d exp=1500", if0.pid_out); end
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (if0.out_valid || if0.busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL ll_ignored got=%b exp=0", seen); end
    run_sample(4'b1001, lat);
    checks++; if (if0.line_lost !== 1'b0)     begin failures++; $display("FAIL ll_clear got=%b exp=0", if0.line_lost); end
    checks++; if (if0.overrun !== 1'b1)       begin failures++; $display("FAIL ll_sticky got=%b exp=1", if0.overrun); end
  endtask

  // Reset in TERM aborts the sample; a tick on the first free edge is taken.
  task automatic test_rst_mid();
    int lat;
    bit seen;
    do_reset();
    set_en(1'b1, 1'b0, 1'b0);
    run_sample(4'b1110, lat);
    @(negedge clk);
    drive(4'b1110, 1'b1);
    @(posedge clk); #1;          // CAP
    drive(4'b1110, 1'b0);
    @(posedge clk);              // TERM
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (if0.out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0)          begin failures++; $display("FAIL rm_no_valid got=%b exp=0", seen); end
    checks++; if (if0.pid_out !== 16'sd0) begin failures++; $display("FAIL rm_pid_out got=%0d exp=0", if0.pid_out); end
    checks++; if (if0.busy !== 1'b0)      begin failures++; $display("FAIL rm_busy got=%b exp=0", if0.busy); end
    @(negedge clk);
    rst = 1'b0;
    drive(4'b1110, 1'b1);
    @(posedge clk); #1;
    drive(4'b1110, 1'b0);
    checks++; if (if0.busy !== 1'b1)      begin failures++; $display("FAIL rm_accept got=%b exp=1", if0.busy); end
    wait_valid(lat);
    checks++; if (lat != 4)                  begin failures++; $display("FAIL rm_latency got=%0d exp=4", lat); end
    checks++; if (if0.pid_out !== 16'sd1500) begin failures++; $display("FAIL rm_pid_out2 got=%0d exp=1500", if0.pid_out); end
  endtask

  initial begin
    drive(4'b1111, 1'b0);
    set_en(1'b0, 1'b0, 1'b0);
    test_reset();
    test_center();
    test_kp();
    test_ki();
    test_kd();
    test_antiwindup();
    test_line_lost();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
